mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/urv_cfg.sv | 17 +
 rtl/urv_typedef.sv | 26 ++
 rtl/rr_pick.sv | 47 ++++
 rtl/mem_arb.sv | 141 ++++++++++++++
 tb/tb_mem_arb.sv | 328 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package    : mem_arb_pkg
// Purpose    : Helper functions local to the memory arbiter.
// Ports      : none (package)
// Revision   : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Index following idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/urv_cfg.sv
`default_nettype none
// ============================================================================
// Package    : urv_cfg
// Purpose    : Build-time configuration limits shared by the memory fabric.
//              Holds the legal range and default for the requester count of
//              the memory arbiter.
// Ports      : none (package)
// Revision   : 1.0 - initial release
// ============================================================================
package urv_cfg;

  localparam int N_MST_MIN     = 2;
  localparam int N_MST_MAX     = 8;
  localparam int N_MST_DEFAULT = 2;

endpackage : urv_cfg
`default_nettype wire

// File: rtl/urv_typedef.sv
`default_nettype none
// ============================================================================
// Package    : urv_typedef
// Purpose    : Memory request/response payload types used on every port of
//              the memory fabric.
// Ports      : none (package)
// Revision   : 1.0 - initial release
// ============================================================================
package urv_typedef;

  // Request payload: write enable, word address, write data, byte enables.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  // Response payload: read data and an error flag.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;

endpackage : urv_typedef
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module     : rr_pick
// Purpose    : Combinational round-robin picker. Returns the first set bit
//              of the request vector, searching upward from a start pointer
//              and wrapping modulo N.
// Ports      : i_req [N-1:0]  - request vector
//              i_ptr [IW-1:0] - index where the search starts
//              o_idx [IW-1:0] - winning index (0 when nothing requests)
//              o_any          - at least one request bit is set
// Revision   : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;

  // Walk the offsets from farthest to nearest so that the candidate
  // closest to the pointer is the last one written and therefore wins.
  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      w_cand = w_sum[IW-1:0];
      if (i_req[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module     : mem_arb
// Purpose    : Round-robin arbiter sharing one downstream memory port among
//              N_MST requesters. Exactly one transaction is outstanding
//              downstream; the grant is held from request through response.
// Ports      : clk_i, rst_i          - clock, synchronous active-high reset
//              m_req_valid/ready/m_req   - per-requester request channel
//              m_resp_valid/ready/m_resp - per-requester response channel
//              s_req_valid/ready/s_req   - shared downstream request channel
//              s_resp_valid/ready/s_resp - shared downstream response channel
//              busy                 - transaction in flight
//              gnt_idx              - current or last grant owner
// Revision   : 1.0 - initial release
// ============================================================================
module mem_arb
  import urv_cfg::*;
  import urv_typedef::*;
  import mem_arb_pkg::*;
#(
  parameter int N_MST = N_MST_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_MST-1:0]           m_req_valid,
  output logic [N_MST-1:0]           m_req_ready,
  input  mem_req_t [N_MST-1:0]       m_req,
  output logic [N_MST-1:0]           m_resp_valid,
  input  logic [N_MST-1:0]           m_resp_ready,
  output mem_resp_t [N_MST-1:0]      m_resp,
  output logic                       s_req_valid,
  input  logic                       s_req_ready,
  output mem_req_t                   s_req,
  input  logic                       s_resp_valid,
  output logic                       s_resp_ready,
  input  mem_resp_t                  s_resp,
  output logic                       busy,
  output logic [$clog2(N_MST)-1:0]   gnt_idx
);

  localparam int IW = $clog2(N_MST);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [IW-1:0] r_gnt_idx;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] w_gnt_nxt;
  logic [IW-1:0] w_ptr_nxt;
  logic [IW-1:0] w_win_idx;
  logic          w_win_any;

  rr_pick #(
    .N  (N_MST),
    .IW (IW)
  ) u_rr_pick (
    .i_req (m_req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_win_idx),
    .o_any (w_win_any)
  );

  // State register together with the grant owner and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ARB_IDLE;
      r_gnt_idx <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt_idx <= w_gnt_nxt;
      r_rr_ptr  <= w_ptr_nxt;
    end
  end

  // Next-state logic. The pointer only advances on a completed response,
  // so an owner that withdraws its request keeps first place next time.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt_idx;
    w_ptr_nxt   = r_rr_ptr;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_win_any) begin
          w_state_nxt = ARB_REQ;
          w_gnt_nxt   = w_win_idx;
        end
      end
      ARB_REQ: begin
        if (!m_req_valid[r_gnt_idx]) begin
          w_state_nxt = ARB_IDLE;
        end else if (s_req_ready) begin
          w_state_nxt = ARB_RSP;
        end
      end
      ARB_RSP: begin
        if (s_resp_valid && m_resp_ready[r_gnt_idx]) begin
          w_state_nxt = ARB_IDLE;
          w_ptr_nxt   = IW'(rr_next(int'(r_gnt_idx), N_MST));
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Output steering. Payloads are pure muxes; only valid/ready depend on
  // state. Every requester sees s_resp and qualifies it with its own valid.
  always_comb begin
    m_req_ready  = '0;
    m_resp_valid = '0;
    s_req_valid  = 1'b0;
    s_resp_ready = 1'b0;
    s_req        = m_req[r_gnt_idx];
    for (int i = 0; i < N_MST; i++) begin
      m_resp[i] = s_resp;
    end
    busy    = (r_state != ARB_IDLE);
    gnt_idx = r_gnt_idx;
    unique case (r_state)
      ARB_REQ: begin
        s_req_valid              = m_req_valid[r_gnt_idx];
        m_req_ready[r_gnt_idx]   = s_req_ready;
      end
      ARB_RSP: begin
        m_resp_valid[r_gnt_idx]  = s_resp_valid;
        s_resp_ready             = m_resp_ready[r_gnt_idx];
      end
      default: begin
      end
    endcase
  end

endmodule : mem_arb
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module     : tb_mem_arb
// Purpose    : Self-checking bench for mem_arb (N_MST = 2). Directed
//              scenarios followed by randomized traffic, all cycles compared
//              against a transaction-level reference model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mem_arb;
  import urv_typedef::*;

  localparam int N = 2;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [N-1:0]        m_req_valid;
  logic [N-1:0]        m_req_ready;
  mem_req_t [N-1:0]    m_req;
  logic [N-1:0]        m_resp_valid;
  logic [N-1:0]        m_resp_ready;
  mem_resp_t [N-1:0]   m_resp;
  logic                s_req_valid;
  logic                s_req_ready;
  mem_req_t            s_req;
  logic                s_resp_valid;
  logic                s_resp_ready;
  mem_resp_t           s_resp;
  logic                busy;
  logic [0:0]          gnt_idx;

  always #5 clk_i = ~clk_i;

  mem_arb #(.N_MST(N)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_req        (m_req),
    .m_resp_valid (m_resp_valid),
    .m_resp_ready (m_resp_ready),
    .m_resp       (m_resp),
    .s_req_valid  (s_req_valid),
    .s_req_ready  (s_req_ready),
    .s_req        (s_req),
    .s_resp_valid (s_resp_valid),
    .s_resp_ready (s_resp_ready),
    .s_resp       (s_resp),
    .busy         (busy),
    .gnt_idx      (gnt_idx)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: who owns the port, whether its request has
  // been handed downstream, where the next search starts, last grant.
  int mo_owner = -1;
  bit mo_acc   = 1'b0;
  int mo_ptr   = 0;
  int mo_gnt   = 0;
  bit mo_known = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_rv;
    logic         e_srv;
    logic         e_srr;
    if (!mo_known) return;
    e_rdy = '0;
    e_rv  = '0;
    e_srv = 1'b0;
    e_srr = 1'b0;
    if (mo_owner >= 0) begin
      if (!mo_acc) begin
        e_rdy[mo_owner] = s_req_ready;
        e_srv           = m_req_valid[mo_owner];
      end else begin
        e_rv[mo_owner] = s_resp_valid;
        e_srr          = m_resp_ready[mo_owner];
      end
    end
    chk("busy", busy, (mo_owner >= 0));
    chk("gnt_idx", gnt_idx, mo_gnt);
    chk("m_req_ready", m_req_ready, e_rdy);
    chk("m_resp_valid", m_resp_valid, e_rv);
    chk("s_req_valid", s_req_valid, e_srv);
    chk("s_resp_ready", s_resp_ready, e_srr);
    if (mo_owner >= 0 && !mo_acc) chk("s_req", s_req, m_req[mo_owner]);
    for (int i = 0; i < N; i++) chk("m_resp", m_resp[i], s_resp);
  endtask

  task automatic model_update();
    bit found;
    int j;
    if (rst_i) begin
      mo_known = 1'b1;
      mo_owner = -1;
      mo_acc   = 1'b0;
      mo_ptr   = 0;
      mo_gnt   = 0;
    end else if (mo_known) begin
      if (mo_owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          j = (mo_ptr + k) % N;
          if (!found && m_req_valid[j]) begin
            found    = 1'b1;
            mo_owner = j;
            mo_gnt   = j;
          end
        end
      end else if (!mo_acc) begin
        if (!m_req_valid[mo_owner]) mo_owner = -1;
        else if (s_req_ready)       mo_acc = 1'b1;
      end else if (s_resp_valid && m_resp_ready[mo_owner]) begin
        mo_ptr   = (mo_owner + 1) % N;
        mo_owner = -1;
        mo_acc   = 1'b0;
      end
    end
  endtask

  // One clock: check settled outputs, advance at the edge, return at negedge.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    m_req_valid  = '0;
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b0;
    m_resp_ready = '0;
    s_resp       = '0;
    for (int i = 0; i < N; i++) m_req[i] = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  // Runs one full request/response exchange with whatever requests are up.
  task automatic do_txn(output int g);
    int n;
    n = 0;
    #1;
    while (!s_req_valid && n < 8) begin
      step();
      n++;
    end
    chk("txn_req_timeout", s_req_valid, 1'b1);
    g = int'(gnt_idx);
    s_req_ready = 1'b1;
    step();
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b1;
    s_resp.rdata = $urandom;
    s_resp.err   = 1'b0;
    m_resp_ready = '1;
    step();
    s_resp_valid = 1'b0;
    m_resp_ready = '0;
  endtask

  initial begin
    int g;
    int exp_seq [4];
    exp_seq = '{0, 1, 0, 1};
    rst_i = 1'b1;
    idle_inputs();
    do_reset();
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_gnt", gnt_idx, 1'b0);
    chk("reset_svalid", s_req_valid, 1'b0);

    // Single read from port 0.
    m_req_valid      = 2'b01;
    m_req[0].we      = 1'b0;
    m_req[0].addr    = 32'h10;
    step();
    chk("r31_s_req_valid", s_req_valid, 1'b1);
    chk("r31_addr", s_req.addr, 32'h10);
    s_req_ready = 1'b1;
    step();
    s_req_ready  = 1'b0;
    m_req_valid  = 2'b00;
    s_resp_valid = 1'b1;
    s_resp.rdata = 32'hDEADBEEF;
    s_resp.err   = 1'b0;
    m_resp_ready = 2'b01;
    #1;
    chk("r31_resp_valid", m_resp_valid, 2'b01);
    chk("r31_rdata", m_resp[0].rdata, 32'hDEADBEEF);
    step();
    s_resp_valid = 1'b0;
    m_resp_ready = '0;
    #1;
    chk("r31_busy_after", busy, 1'b0);

    // Both ports requesting continuously alternate.
    do_reset();
    m_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      do_txn(g);
      chk("r32_gnt_seq", g, exp_seq[k]);
    end
    m_req_valid = '0;
    step();

    // Downstream request stall, then response stall.
    do_reset();
    m_req_valid = 2'b10;
    m_req[1].addr = $urandom;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("r33_svalid", s_req_valid, 1'b1);
      chk("r33_mready", m_req_ready, 2'b00);
      chk("r33_gnt", gnt_idx, 1'b1);
    end
    s_req_ready = 1'b1;
    step();
    s_req_ready  = 1'b0;
    m_req_valid  = '0;
    s_resp_valid = 1'b1;
    s_resp.rdata = $urandom;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("r34_sresp_ready", s_resp_ready, 1'b0);
      chk("r34_busy", busy, 1'b1);
      step();
    end
    m_resp_ready = 2'b10;
    #1;
    chk("r34_sresp_ready_go", s_resp_ready, 1'b1);
    step();
    s_resp_valid = 1'b0;
    m_resp_ready = '0;
    #1;
    chk("r34_busy_done", busy, 1'b0);

    // Reset while waiting for a response.
    m_req_valid = 2'b01;
    step();
    s_req_ready = 1'b1;
    step();
    s_req_ready = 1'b0;
    m_req_valid = '0;
    #1;
    chk("r35_in_rsp", busy, 1'b1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    chk("r35_busy", busy, 1'b0);
    chk("r35_gnt", gnt_idx, 1'b0);
    chk("r35_mready", m_req_ready, 2'b00);
    chk("r35_mrv", m_resp_valid, 2'b00);
    chk("r35_svalid", s_req_valid, 1'b0);
    m_req_valid = 2'b10;
    step();
    chk("r35_regrant", gnt_idx, 1'b1);
    chk("r35_regrant_sv", s_req_valid, 1'b1);
    do_txn(g);
    m_req_valid = '0;
    step();

    // Owner withdraws its request before acceptance.
    do_reset();
    m_req_valid = 2'b01;
    do_txn(g);
    m_req_valid = 2'b10;
    step();
    chk("r36_gnt1", gnt_idx, 1'b1);
    m_req_valid = 2'b00;
    step();
    chk("r36_idle", busy, 1'b0);
    m_req_valid = 2'b11;
    step();
    chk("r36_rewin", gnt_idx, 1'b1);
    do_txn(g);
    m_req_valid = '0;
    step();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst_i        = ($urandom_range(0, 199) == 0);
      m_req_valid  = N'($urandom_range(0, 3));
      s_req_ready  = 1'($urandom);
      s_resp_valid = 1'($urandom);
      m_resp_ready = N'($urandom);
      s_resp.rdata = $urandom;
      s_resp.err   = 1'($urandom);
      for (int i = 0; i < N; i++) begin
        m_req[i].we    = 1'($urandom);
        m_req[i].addr  = $urandom;
        m_req[i].wdata = $urandom;
        m_req[i].be    = 4'($urandom);
      end
      step();
    end
    rst_i = 1'b0;
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_arb
`default_nettype wire
